// File: rtl/echo_distance_calc.sv
// Ultrasonic echo ranger: fires a trigger pulse, times the synchronized echo in microseconds,
// then converts to millimetres as floor(echo_us * velo / 1000) using a serial multiply and divide.
module echo_distance_calc #(
    parameter int CLK_FREQ_MHZ = 50,
    parameter int TRIG_US      = 10,
    parameter int TIMEOUT_US   = 30000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        echo,
    input  logic [7:0]  velo,
    output logic        trig,
    output logic        busy,
    output logic [15:0] dist_mm,
    output logic        dist_valid,
    output logic        timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_MUL, S_DIV, S_DONE
    } state_t;

    localparam int          CW           = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [CW-1:0] CYC_LAST   = CW'(CLK_FREQ_MHZ - 1);
    localparam logic [15:0] TRIG_LAST    = 16'(TRIG_US - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
    localparam logic [10:0] DIVISOR      = 11'd1000;

    state_t        state_q, state_d;
    logic          echo_meta_q, echo_meta_d;
    logic          echo_sync_q, echo_sync_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [15:0]   us_q, us_d;
    logic [4:0]    step_q, step_d;
    logic [23:0]   mcand_q, mcand_d;
    logic [7:0]    mplier_q, mplier_d;
    logic [23:0]   acc_q, acc_d;
    logic [9:0]    rem_q, rem_d;
    logic          trig_q, trig_d;
    logic [15:0]   dist_q, dist_d;
    logic          dist_valid_q, dist_valid_d;
    logic          timeout_q, timeout_d;
    logic          tick;
    logic [10:0]   div_shift;

    always_comb begin
        state_d      = state_q;
        echo_meta_d  = echo;
        echo_sync_d  = echo_meta_q;
        cyc_d        = cyc_q;
        us_d         = us_q;
        step_d       = step_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        rem_d        = rem_q;
        trig_d       = trig_q;
        dist_d       = dist_q;
        dist_valid_d = 1'b0;
        timeout_d    = 1'b0;
        tick         = (cyc_q == CYC_LAST);
        div_shift    = {rem_q, acc_q[23]};

        // Timing states share one free-running µs timebase; each state entry restarts it.
        if (state_q == S_TRIG || state_q == S_WAIT_RISE || state_q == S_MEASURE) begin
            cyc_d = tick ? '0 : cyc_q + 1'b1;
            us_d  = tick ? us_q + 16'd1 : us_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_TRIG;
                    trig_d  = 1'b1;
                    cyc_d   = '0;
                    us_d    = '0;
                end
            end
            S_TRIG: begin
                if (tick && us_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                    trig_d  = 1'b0;
                    cyc_d   = '0;
                    us_d    = '0;
                end
            end
            S_WAIT_RISE: begin
                if (echo_sync_q) begin
                    state_d = S_MEASURE;
                    cyc_d   = '0;
                    us_d    = '0;
                end else if (tick && us_q == TIMEOUT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_MEASURE: begin
                // The cycle echo falls is the only cycle velo is sampled.
                if (!echo_sync_q) begin
                    state_d  = S_MUL;
                    mcand_d  = {8'd0, us_q};
                    mplier_d = velo;
                    acc_d    = '0;
                    step_d   = '0;
                end else if (tick && us_q == TIMEOUT_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                step_d   = step_q + 5'd1;
                if (step_q == 5'd7) begin
                    state_d = S_DIV;
                    step_d  = '0;
                    rem_d   = '0;
                end
            end
            S_DIV: begin
                // acc holds the dividend shifting out at the top and the quotient shifting in below.
                if (div_shift >= DIVISOR) begin
                    rem_d = 10'(div_shift - DIVISOR);
                    acc_d = {acc_q[22:0], 1'b1};
                end else begin
                    rem_d = div_shift[9:0];
                    acc_d = {acc_q[22:0], 1'b0};
                end
                step_d = step_q + 5'd1;
                if (step_q == 5'd23) begin
                    state_d = S_DONE;
                    step_d  = '0;
                end
            end
            S_DONE: begin
                dist_d       = acc_q[15:0];
                dist_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            echo_meta_q  <= 1'b0;
            echo_sync_q  <= 1'b0;
            cyc_q        <= '0;
            us_q         <= '0;
            step_q       <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            rem_q        <= '0;
            trig_q       <= 1'b0;
            dist_q       <= '0;
            dist_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            echo_meta_q  <= echo_meta_d;
            echo_sync_q  <= echo_sync_d;
            cyc_q        <= cyc_d;
            us_q         <= us_d;
            step_q       <= step_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            rem_q        <= rem_d;
            trig_q       <= trig_d;
            dist_q       <= dist_d;
            dist_valid_q <= dist_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign trig       = trig_q;
    assign busy       = (state_q != S_IDLE);
    assign dist_mm    = dist_q;
    assign dist_valid = dist_valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_echo_distance_calc.sv
// Randomized bench for echo_distance_calc: drives echo pulses of known length and compares
// distance, latency, trigger width and timeout behaviour against an arithmetic reference.
module tb_echo_distance_calc;

    localparam int F       = 2;
    localparam int TRIG    = 10;
    localparam int TO      = 5900;
    localparam int LATENCY = 36;  // 2 synchronizer stages + 34 cycles from synced fall

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        echo = 1'b0;
    logic [7:0]  velo = 8'd0;
    logic        trig;
    logic        busy;
    logic [15:0] dist_mm;
    logic        dist_valid;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int dv_cnt  = 0;
    int to_cnt  = 0;
    int overlap = 0;
    logic [15:0] last_dist = 16'd0;

    echo_distance_calc #(.CLK_FREQ_MHZ(F), .TRIG_US(TRIG), .TIMEOUT_US(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .echo(echo), .velo(velo),
        .trig(trig), .busy(busy), .dist_mm(dist_mm), .dist_valid(dist_valid),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dist_valid) dv_cnt++;
        if (timeout) to_cnt++;
        if (dist_valid && timeout) overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_dist(input int us, input int v);
        int p;
        p = (us * v) / 1000;
        return p[15:0];
    endfunction

    // Pulses start and measures how long trig stays high.
    task automatic start_and_trig();
        int n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (trig && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_eq("trig_width", n, TRIG * F);
    endtask

    // mode 0: normal, 1: start re-pulsed during MEASURE, 2: reset during DIV.
    // Echo is held for us*F+1 cycles so the synchronizer leaves exactly 'us' whole µs in MEASURE.
    task automatic run_measure(input int us, input logic [7:0] v_meas, input logic [7:0] v_fall,
                               input logic [7:0] v_after, input int mode);
        int n;
        int dv0;
        int to0;
        logic [15:0] exp_d;
        exp_d = ref_dist(us, v_fall);
        dv0   = dv_cnt;
        to0   = to_cnt;
        velo  = v_meas;
        start_and_trig();
        repeat ($urandom_range(1, 10)) @(negedge clk);
        echo = 1'b1;
        for (int i = 0; i < us * F + 1; i++) begin
            start = (mode == 1 && i == us * F / 2);
            @(negedge clk);
        end
        start = 1'b0;
        echo  = 1'b0;
        velo  = v_fall;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (n == 3) velo = v_after;
            if (mode == 2 && n == 20) break;
            if (dist_valid) break;
        end
        if (mode == 2) begin
            reset_n = 1'b0;
            #1;
            check_eq("rst_trig", trig, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_dist_mm", dist_mm, 0);
            check_eq("rst_flags", {dist_valid, timeout}, 0);
            last_dist = 16'd0;
            @(negedge clk);
            @(negedge clk) reset_n = 1'b1;
            repeat (60) @(negedge clk);
            check_eq("rst_no_valid", dv_cnt, dv0);
            check_eq("rst_no_timeout", to_cnt, to0);
            check_eq("rst_idle", busy, 0);
        end else begin
            check_eq("latency", n, LATENCY);
            check_eq("dist_mm", dist_mm, exp_d);
            last_dist = exp_d;
            @(negedge clk);
            check_eq("valid_one_cycle", dist_valid, 0);
            check_eq("idle_after_done", busy, 0);
            repeat (20) @(negedge clk);
            check_eq("single_valid", dv_cnt, dv0 + 1);
            check_eq("no_timeout", to_cnt, to0);
            check_eq("still_idle", busy, 0);
        end
    endtask

    task automatic run_wait_timeout();
        int n;
        int dv0;
        dv0 = dv_cnt;
        start_and_trig();
        n = 0;
        while (!timeout && n < TO * F + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("wait_timeout_cycles", n, TO * F);
        check_eq("wait_timeout_busy", busy, 0);
        check_eq("wait_timeout_dist", dist_mm, last_dist);
        @(negedge clk);
        check_eq("wait_timeout_pulse", timeout, 0);
        check_eq("wait_timeout_no_valid", dv_cnt, dv0);
    endtask

    task automatic run_measure_timeout();
        int n;
        int dv0;
        dv0 = dv_cnt;
        velo = 8'd200;
        start_and_trig();
        repeat (3) @(negedge clk);
        echo = 1'b1;
        n = 0;
        while (!timeout && n < TO * F + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("meas_timeout_cycles", n, TO * F + 3);
        echo = 1'b0;
        repeat (60) @(negedge clk);
        check_eq("meas_timeout_no_valid", dv_cnt, dv0);
        check_eq("meas_timeout_dist", dist_mm, last_dist);
        check_eq("meas_timeout_busy", busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("reset_trig", trig, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_dist_mm", dist_mm, 0);
        check_eq("reset_valid", dist_valid, 0);
        check_eq("reset_timeout", timeout, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        run_measure(1000, 8'd170, 8'd170, 8'd170, 0);
        run_measure(5882, 8'd170, 8'd170, 8'd170, 0);
        run_measure(2000, 8'd170, 8'd200, 8'd10, 0);
        run_wait_timeout();
        run_measure(300, 8'd90, 8'd0, 8'd255, 0);
        run_measure(0, 8'd170, 8'd170, 8'd170, 0);
        run_measure(1500, 8'd123, 8'd123, 8'd123, 1);
        run_measure_timeout();
        run_measure(1000, 8'd170, 8'd170, 8'd170, 2);
        run_measure(1000, 8'd170, 8'd170, 8'd170, 0);
        for (int k = 0; k < 6; k++) begin
            run_measure(int'($urandom_range(1, 400)), 8'($urandom_range(0, 255)),
                        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
        end

        check_eq("valid_timeout_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_distance_calc.md
ECHO_DISTANCE_CALC -- requirements
Module: echo_distance_calc

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, reset_n.
REQ-002 Parameters SHALL be, one per line:
- CLK_FREQ_MHZ, 50, clk cycles per microsecond.
- TRIG_US, 10, trigger pulse width in µs.
- TIMEOUT_US, 30000, maximum wait or measure time in µs.
REQ-003 Ports SHALL be, one per line:
- clk  input  1  system clock.
- reset_n  input  1  async active-low reset.
- start  input  1  single-cycle measurement request.
- echo  input  1  asynchronous sensor echo.
- velo  input  8  half sound speed, m/s (upstream velocity-adjust stage output).
- trig  output  1  sensor trigger.
- busy  output  1  high whenever FSM is not IDLE.
- dist_mm  output  16  last valid distance, mm.
- dist_valid  output  1  one-cycle pulse when dist_mm updates.
- timeout  output  1  one-cycle pulse on measurement failure.

Function
REQ-004 echo SHALL pass through a 2-flop synchronizer; all echo references below mean the synchronized signal.
REQ-005 A µs tick SHALL come from a cycle counter wrapping at CLK_FREQ_MHZ-1; the cycle counter and the µs counter SHALL clear on entry to TRIG, WAIT_RISE and MEASURE.
REQ-006 FSM states SHALL be IDLE, TRIG, WAIT_RISE, MEASURE, MUL, DIV, DONE.
REQ-007 IDLE: start=1 SHALL move to TRIG next cycle; start in any other state SHALL be ignored, not queued.
REQ-008 TRIG: trig SHALL be 1 for exactly TRIG_US µs (TRIG_US*CLK_FREQ_MHZ cycles), then go to WAIT_RISE with trig=0.
REQ-009 WAIT_RISE: echo=1 SHALL go to MEASURE; µs count reaching TIMEOUT_US SHALL pulse timeout and return to IDLE.
REQ-010 MEASURE: echo_us (16 bit) SHALL count completed µs ticks while echo=1.
REQ-011 In MEASURE, echo=0 SHALL latch echo_us and velo (velo sampled on this cycle only) and go to MUL.
REQ-012 If echo_us reaches TIMEOUT_US while in MEASURE, the block SHALL pulse timeout and go to IDLE; dist_mm SHALL be unchanged.
REQ-013 MUL: product = echo_us*velo SHALL be computed by 8-cycle shift-add into a 24-bit register; no overflow is possible (max 30000*255 = 7,650,000).
REQ-014 DIV: dist = floor(product/1000) SHALL be computed by a 24-cycle restoring divider; the quotient SHALL be truncated to 16 bits (max 7650).
REQ-015 DONE: dist_mm SHALL load the quotient, dist_valid SHALL pulse for one cycle, and the FSM SHALL return to IDLE next cycle.
REQ-016 Latency from synced echo fall to dist_valid SHALL be exactly 1+8+24+1 = 34 cycles.
REQ-017 velo=0 or echo_us=0 SHALL give dist_mm=0 with dist_valid pulsed; neither SHALL be treated as an error.
REQ-018 Changes on velo outside the latch cycle SHALL NOT affect the result in progress.
REQ-019 dist_valid and timeout SHALL never be high in the same cycle.

Reset
REQ-020 reset_n=0 SHALL asynchronously force FSM=IDLE, trig=0, busy=0, dist_mm=0, dist_valid=0, timeout=0, and clear all counters, datapath registers and synchronizer flops.
REQ-021 Reset asserted mid-operation SHALL abort with no dist_valid and no timeout pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-022 Echo pulse: start; echo high 1000 µs; velo=170 -> trig 500 cycles; dist_mm=170; dist_valid 34 cycles after synced echo fall.
REQ-023 Truncation: echo high 5882 µs; velo=170 -> dist_mm=999.
REQ-024 Sample point: echo 2000 µs; velo changes 170->200 during MEASURE and 200->10 during MUL -> dist_mm=400.
REQ-025 Timeout: start with echo held 0 -> timeout pulse at 30000 µs in WAIT_RISE; dist_mm keeps its previous value; busy=0 after.
REQ-026 Ignored start: start re-pulsed during MEASURE -> no restart; exactly one dist_valid; then IDLE.
REQ-027 Reset: reset_n pulsed low during DIV -> all outputs 0 immediately; no pulses; next start gives a correct result.
